// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles N-bit words from an enabled bit stream
// and presents them on a valid/ready output register with sticky error flags.
module shift_deserializer #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         E,
  input  logic         w,
  input  logic         start,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic {IDLE, RECV} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [N-1:0]   data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic [N-1:0]   shifted_c;
  logic [N-1:0]   first_c;

  // Shift register continuation and fresh bit-0 image for the chosen bit order.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_c = {sr_q[N-2:0], w};
      first_c   = {{(N-1){1'b0}}, w};
    end else begin
      shifted_c = {w, sr_q[N-1:1]};
      first_c   = {w, {(N-1){1'b0}}};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (E && start) begin
          sr_d    = first_c;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (E) begin
          if (start) begin
            // Restart wins over completion: drop the partial word.
            ferr_d = 1'b1;
            sr_d   = first_c;
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            sr_d    = shifted_c;
            data_d  = shifted_c;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
            if (valid_q && !out_ready) begin
              ovr_d = 1'b1;
            end
          end else begin
            sr_d  = shifted_c;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == RECV);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: MSB-first and LSB-first N=4 plus an N=2 instance
// sharing one stimulus stream.
module tb_shift_deserializer;

  logic clk = 1'b0;
  logic reset, E, w, start, out_ready;

  logic [3:0] m_data, l_data;
  logic [1:0] t_data;
  logic m_valid, m_busy, m_ferr, m_ovr;
  logic l_valid, l_busy, l_ferr, l_ovr;
  logic t_valid, t_busy, t_ferr, t_ovr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;

  always #5 clk = ~clk;

  shift_deserializer #(.N(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .E(E), .w(w), .start(start), .out_ready(out_ready),
    .data_out(m_data), .out_valid(m_valid), .busy(m_busy), .frame_err(m_ferr), .overrun(m_ovr));

  shift_deserializer #(.N(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .E(E), .w(w), .start(start), .out_ready(out_ready),
    .data_out(l_data), .out_valid(l_valid), .busy(l_busy), .frame_err(l_ferr), .overrun(l_ovr));

  shift_deserializer #(.N(2), .MSB_FIRST(1'b1)) dut_2 (
    .clk(clk), .reset(reset), .E(E), .w(w), .start(start), .out_ready(out_ready),
    .data_out(t_data), .out_valid(t_valid), .busy(t_busy), .frame_err(t_ferr), .overrun(t_ovr));

  // Reference word: seq lists bits in reception order, leftmost (seq[n-1]) first.
  function automatic logic [31:0] model(input int n, input bit msb, input logic [31:0] seq);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = msb ? seq[i] : seq[n-1-i];
    return r;
  endfunction

  task automatic step(input logic e, input logic st, input logic wv);
    E = e; start = st; w = wv;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted with live-looking inputs to show reset wins.
  task automatic do_reset();
    reset = 1'b1; out_ready = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    reset = 1'b0; E = 1'b0; start = 1'b0; w = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] seq, input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) out_ready = rdy_last;
      step(1'b1, (i == 0), seq[n-1-i]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_data !== 4'b0) begin errors++; $display("FAIL reset_data got %b exp 0000", m_data); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", m_busy); end
    checks++; if (m_ferr !== 1'b0 || m_ovr !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", m_ferr, m_ovr); end
  endtask

  task automatic test_msb_nominal();
    logic [3:0] seq;
    do_reset();
    seq = 4'b1011;
    exp_q.push_back(model(4, 1'b1, 32'(seq)));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), seq[3-i]);
      if (i < 3) begin
        checks++; if (m_busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL nom_busy bit %0d got busy %b valid %b exp 1 0", i, m_busy, m_valid); end
      end
    end
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL nom_data got %h exp %h", m_data, got); end
    checks++; if (m_valid !== 1'b1 || m_busy !== 1'b0) begin errors++; $display("FAIL nom_done got valid %b busy %b exp 1 0", m_valid, m_busy); end
  endtask

  task automatic test_lsb_gaps();
    do_reset();
    exp_q.push_back(model(4, 1'b0, 32'(4'b1011)));
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 1'b1, g[0]);
      checks++; if (l_busy !== 1'b1 || l_valid !== 1'b0 || l_ferr !== 1'b0) begin errors++; $display("FAIL gap_hold cycle %0d got busy %b valid %b ferr %b exp 1 0 0", g, l_busy, l_valid, l_ferr); end
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    got = exp_q.pop_front();
    checks++; if (32'(l_data) !== got) begin errors++; $display("FAIL lsb_data got %b exp %b", l_data, got[3:0]); end
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b exp 1", l_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(model(4, 1'b1, 32'(4'b1010)));
    send_frame(4, 32'(4'b1010), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL b2b_first got %b exp %b", m_data, got[3:0]); end
    exp_q.push_back(model(4, 1'b1, 32'(4'b0110)));
    send_frame(4, 32'(4'b0110), 1'b1);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL b2b_second got %b exp %b", m_data, got[3:0]); end
    checks++; if (m_valid !== 1'b1 || m_ovr !== 1'b0) begin errors++; $display("FAIL b2b_flags got valid %b ovr %b exp 1 0", m_valid, m_ovr); end
  endtask

  task automatic test_overrun();
    do_reset();
    exp_q.push_back(model(4, 1'b1, 32'(4'b1100)));
    send_frame(4, 32'(4'b1100), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got || m_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first got %b ovr %b exp %b 0", m_data, m_ovr, got[3:0]); end
    exp_q.push_back(model(4, 1'b1, 32'(4'b0011)));
    send_frame(4, 32'(4'b0011), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL ovr_second got %b exp %b", m_data, got[3:0]); end
    checks++; if (m_ovr !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL ovr_set got ovr %b valid %b exp 1 1", m_ovr, m_valid); end
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    checks++; if (m_valid !== 1'b0 || m_ovr !== 1'b1) begin errors++; $display("FAIL ovr_drain got valid %b ovr %b exp 0 1", m_valid, m_ovr); end
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL ovr_hold got %b exp %b", m_data, got[3:0]); end
  endtask

  task automatic test_frame_err();
    do_reset();
    exp_q.push_back(model(4, 1'b1, 32'(4'b1110)));
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (m_ferr !== 1'b1 || m_busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL ferr_set got ferr %b busy %b valid %b exp 1 1 0", m_ferr, m_busy, m_valid); end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ferr_early got valid %b exp 0", m_valid); end
    step(1'b1, 1'b0, 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got || m_valid !== 1'b1) begin errors++; $display("FAIL ferr_word got %b valid %b exp %b 1", m_data, m_valid, got[3:0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_q.push_back(model(4, 1'b1, 32'(4'b1111)));
    send_frame(4, 32'(4'b1111), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got) begin errors++; $display("FAIL rmid_pre got %b exp %b", m_data, got[3:0]); end
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    checks++; if (m_data !== 4'b0 || m_valid !== 1'b0 || m_busy !== 1'b0 || m_ferr !== 1'b0 || m_ovr !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got data %b valid %b busy %b ferr %b ovr %b exp all 0", m_data, m_valid, m_busy, m_ferr, m_ovr);
    end
    exp_q.push_back(model(4, 1'b1, 32'(4'b0011)));
    send_frame(4, 32'(4'b0011), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(m_data) !== got || m_valid !== 1'b1) begin errors++; $display("FAIL rmid_word got %b valid %b exp %b 1", m_data, m_valid, got[3:0]); end
    checks++; if (m_ferr !== 1'b0 || m_ovr !== 1'b0) begin errors++; $display("FAIL rmid_flags got ferr %b ovr %b exp 0 0", m_ferr, m_ovr); end
  endtask

  task automatic test_n2();
    do_reset();
    exp_q.push_back(model(2, 1'b1, 32'(2'b10)));
    send_frame(2, 32'(2'b10), 1'b0);
    got = exp_q.pop_front();
    checks++; if (32'(t_data) !== got || t_valid !== 1'b1 || t_busy !== 1'b0) begin errors++; $display("FAIL n2_word got %b valid %b busy %b exp %b 1 0", t_data, t_valid, t_busy, got[1:0]); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (t_ferr !== 1'b1 || t_busy !== 1'b1 || t_data !== 2'b10) begin errors++; $display("FAIL n2_restart got ferr %b busy %b data %b exp 1 1 10", t_ferr, t_busy, t_data); end
    exp_q.push_back(model(2, 1'b1, 32'(2'b11)));
    step(1'b1, 1'b0, 1'b1);
    got = exp_q.pop_front();
    checks++; if (32'(t_data) !== got || t_ovr !== 1'b1) begin errors++; $display("FAIL n2_ovr got %b ovr %b exp %b 1", t_data, t_ovr, got[1:0]); end
  endtask

  initial begin
    reset = 1'b1; E = 1'b0; w = 1'b0; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_msb_nominal();
    test_lsb_gaps();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_n2();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
